// File: rtl/lsu_mem_stage.sv
// Load/store memory-access stage: one byte/half/word access per request over a req/ack bus.
// Optional LSU_TIMEOUT_EN adds an ack timeout (TIMEOUT_CYCLES) reported through bus_err_o.
module lsu_mem_stage #(
  parameter int unsigned XLEN = 32
`ifdef LSU_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            load_i,
  input  logic            store_i,
  input  logic [2:0]      fun3_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] store_data_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] load_data_o,
  output logic            misalign_err_o,
  output logic            bus_err_o,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  output logic [3:0]      dmem_wstrb_o,
  input  logic            dmem_ack_i,
  input  logic [XLEN-1:0] dmem_rdata_i
);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  localparam logic [1:0] SzByte = 2'b00;
  localparam logic [1:0] SzHalf = 2'b01;
  localparam logic [1:0] SzWord = 2'b10;

  state_e          state_q, state_d;
  logic            is_load_q, is_load_d;
  logic            uns_q, uns_d;
  logic [1:0]      size_q, size_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] sdata_q, sdata_d;
  logic [XLEN-1:0] ldata_q, ldata_d;
  logic            merr_q, merr_d;
  logic            berr_q, berr_d;

  logic       op_legal;
  logic       aligned;
  logic [1:0] in_size;
  logic [7:0] lane_byte;
  logic [15:0] lane_half;
  logic [XLEN-1:0] ext_data;

  always_comb begin
    op_legal = 1'b0;
    in_size  = SzByte;
    if (load_i) begin
      case (fun3_i)
        3'b000, 3'b100: begin op_legal = 1'b1; in_size = SzByte; end
        3'b001, 3'b101: begin op_legal = 1'b1; in_size = SzHalf; end
        3'b010, 3'b110: begin op_legal = 1'b1; in_size = SzWord; end
        default: ;
      endcase
    end else begin
      case (fun3_i)
        3'b000:  begin op_legal = 1'b1; in_size = SzByte; end
        3'b001:  begin op_legal = 1'b1; in_size = SzHalf; end
        3'b010:  begin op_legal = 1'b1; in_size = SzWord; end
        default: ;
      endcase
    end
    case (in_size)
      SzHalf:  aligned = ~addr_i[0];
      SzWord:  aligned = (addr_i[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  // Lane extraction from the raw read word using the captured byte offset.
  always_comb begin
    case (addr_q[1:0])
      2'b00:   lane_byte = dmem_rdata_i[7:0];
      2'b01:   lane_byte = dmem_rdata_i[15:8];
      2'b10:   lane_byte = dmem_rdata_i[23:16];
      default: lane_byte = dmem_rdata_i[31:24];
    endcase
    lane_half = addr_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (size_q)
      SzByte:  ext_data = {{24{lane_byte[7] & ~uns_q}}, lane_byte};
      SzHalf:  ext_data = {{16{lane_half[15] & ~uns_q}}, lane_half};
      default: ext_data = dmem_rdata_i;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT_CYCLES);
  logic [7:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d   = state_q;
    is_load_d = is_load_q;
    uns_d     = uns_q;
    size_d    = size_q;
    addr_d    = addr_q;
    sdata_d   = sdata_q;
    ldata_d   = ldata_q;
    merr_d    = merr_q;
    berr_d    = berr_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start_i && (load_i || store_i)) begin
          is_load_d = load_i;
          uns_d     = fun3_i[2];
          size_d    = in_size;
          addr_d    = addr_i;
          sdata_d   = store_data_i;
          ldata_d   = '0;
          berr_d    = 1'b0;
`ifdef LSU_TIMEOUT_EN
          cnt_d     = '0;
`endif
          if ((load_i ^ store_i) && op_legal && aligned) begin
            merr_d  = 1'b0;
            state_d = StReq;
          end else begin
            merr_d  = 1'b1;
            state_d = StResp;
          end
        end
      end
      StReq: begin
        if (dmem_ack_i) begin
          ldata_d = is_load_q ? ext_data : '0;
          state_d = StResp;
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_q == TimeoutCnt) begin
          ldata_d = '0;
          berr_d  = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      is_load_q <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= SzByte;
      addr_q    <= '0;
      sdata_q   <= '0;
      ldata_q   <= '0;
      merr_q    <= 1'b0;
      berr_q    <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      is_load_q <= is_load_d;
      uns_q     <= uns_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      sdata_q   <= sdata_d;
      ldata_q   <= ldata_d;
      merr_q    <= merr_d;
      berr_q    <= berr_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  // Bus outputs are zero outside REQ so idle and reset state read as all-zero.
  always_comb begin
    busy_o         = (state_q != StIdle);
    done_o         = (state_q == StResp);
    load_data_o    = done_o ? ldata_q : '0;
    misalign_err_o = done_o & merr_q;
`ifdef LSU_TIMEOUT_EN
    bus_err_o      = done_o & berr_q;
`else
    bus_err_o      = 1'b0;
`endif
    dmem_req_o     = (state_q == StReq);
    dmem_we_o      = dmem_req_o & ~is_load_q;
    dmem_addr_o    = dmem_req_o ? {addr_q[XLEN-1:2], 2'b00} : '0;
    dmem_wdata_o   = '0;
    dmem_wstrb_o   = 4'b0000;
    if (dmem_we_o) begin
      case (size_q)
        SzByte: begin
          dmem_wstrb_o = 4'b0001 << addr_q[1:0];
          dmem_wdata_o = {4{sdata_q[7:0]}};
        end
        SzHalf: begin
          dmem_wstrb_o = addr_q[1] ? 4'b1100 : 4'b0011;
          dmem_wdata_o = {2{sdata_q[15:0]}};
        end
        default: begin
          dmem_wstrb_o = 4'b1111;
          dmem_wdata_o = sdata_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage: expected results queued at issue, checked at done.
// Define LSU_TIMEOUT_EN to also exercise the ack timeout with TIMEOUT_CYCLES=4.
module tb_lsu_mem_stage;

  localparam int TbTimeout = 4;

  typedef struct {
    logic [31:0] ld;
    logic        merr;
    logic        berr;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, start, load, store;
  logic [2:0]  fun3;
  logic [31:0] addr, store_data;
  logic        busy, done, misalign_err, bus_err;
  logic [31:0] load_data;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  lsu_mem_stage #(
    .XLEN(32)
`ifdef LSU_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TbTimeout)
`endif
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .load_i(load), .store_i(store),
    .fun3_i(fun3), .addr_i(addr), .store_data_i(store_data), .busy_o(busy),
    .done_o(done), .load_data_o(load_data), .misalign_err_o(misalign_err),
    .bus_err_o(bus_err), .dmem_req_o(dmem_req), .dmem_we_o(dmem_we),
    .dmem_addr_o(dmem_addr), .dmem_wdata_o(dmem_wdata), .dmem_wstrb_o(dmem_wstrb),
    .dmem_ack_i(dmem_ack), .dmem_rdata_i(dmem_rdata)
  );

  task automatic drive_idle();
    start = 0; load = 0; store = 0; fun3 = 3'b000; addr = '0; store_data = '0;
  endtask

  // Issues one op; ack comes on the (waits+1)-th REQ cycle. hold keeps start high
  // with a different op while busy to prove it is ignored.
  task automatic do_op(input string name, input logic ld, input logic st,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                       input logic [31:0] rd, input int waits, input logic exp_req,
                       input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                       input logic [31:0] exp_wdata, input logic [31:0] exp_ld,
                       input logic exp_merr, input logic exp_berr, input int exp_lat,
                       input logic hold);
    exp_t e;
    int   n, reqc, busyc;
    bit   seen;
    e = '{ld: exp_ld, merr: exp_merr, berr: exp_berr, lat: exp_lat};
    sb_q.push_back(e);
    start = 1; load = ld; store = st; fun3 = f3; addr = a; store_data = sd; dmem_rdata = rd;
    @(posedge clk); #1;
    if (hold) begin
      load = 0; store = 1; fun3 = 3'b010; addr = 32'h0000_0F00; store_data = 32'h1111_1111;
    end else begin
      start = 0;
    end
    n = 0; reqc = 0; busyc = 0; seen = 0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      if (busy) busyc++;
      if (dmem_req) begin
        reqc++;
        checks++;
        if (dmem_addr !== exp_addr || dmem_we !== st || dmem_wstrb !== exp_strb ||
            (st && dmem_wdata !== exp_wdata)) begin
          errors++;
          $display("FAIL %s req: addr=%h we=%b strb=%b wdata=%h want addr=%h we=%b strb=%b wdata=%h",
                   name, dmem_addr, dmem_we, dmem_wstrb, dmem_wdata, exp_addr, st, exp_strb,
                   exp_wdata);
        end
        if (reqc > waits) dmem_ack = 1;
      end
      if (done) begin
        seen  = 1;
        start = 0;
        e     = sb_q.pop_front();
        checks++;
        if (load_data !== e.ld) begin
          errors++;
          $display("FAIL %s load_data: got %h want %h", name, load_data, e.ld);
        end
        checks++;
        if (misalign_err !== e.merr || bus_err !== e.berr) begin
          errors++;
          $display("FAIL %s flags: got merr=%b berr=%b want merr=%b berr=%b",
                   name, misalign_err, bus_err, e.merr, e.berr);
        end
        checks++;
        if (n !== e.lat || busyc !== e.lat) begin
          errors++;
          $display("FAIL %s latency: got done@%0d busy=%0d want %0d", name, n, busyc, e.lat);
        end
      end
      @(posedge clk); #1;
      dmem_ack = 0;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s done: not seen within %0d cycles", name, n);
      void'(sb_q.pop_front());
    end
    checks++;
    if ((reqc > 0) !== exp_req) begin
      errors++;
      $display("FAIL %s req_issued: got %b want %b", name, reqc > 0, exp_req);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done: got done=%b busy=%b want 0 0", name, done, busy);
    end
    drive_idle();
  endtask

  task automatic test_reset();
    rst = 1; drive_idle(); dmem_ack = 0; dmem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, misalign_err, bus_err, dmem_req, dmem_we, dmem_wstrb} !== 10'b0 ||
        load_data !== 32'h0 || dmem_addr !== 32'h0 || dmem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset outputs: busy=%b done=%b req=%b addr=%h ld=%h want all zero",
               busy, done, dmem_req, dmem_addr, load_data);
    end
    rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_loads();
    do_op("lw", 1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 1, 32'h100, 4'b0000, 0,
          32'hDEADBEEF, 0, 0, 2, 0);
    do_op("lb", 1, 0, 3'b000, 32'h103, 0, 32'h80123456, 0, 1, 32'h100, 4'b0000, 0,
          32'hFFFFFF80, 0, 0, 2, 0);
    do_op("lbu", 1, 0, 3'b100, 32'h103, 0, 32'h80123456, 1, 1, 32'h100, 4'b0000, 0,
          32'h00000080, 0, 0, 3, 0);
    do_op("lhu", 1, 0, 3'b101, 32'h102, 0, 32'h80123456, 0, 1, 32'h100, 4'b0000, 0,
          32'h00008012, 0, 0, 2, 0);
    do_op("lh", 1, 0, 3'b001, 32'h102, 0, 32'h80123456, 0, 1, 32'h100, 4'b0000, 0,
          32'hFFFF8012, 0, 0, 2, 0);
    do_op("lb_pos", 1, 0, 3'b000, 32'h101, 0, 32'h80123456, 0, 1, 32'h100, 4'b0000, 0,
          32'h00000034, 0, 0, 2, 0);
    do_op("lw110", 1, 0, 3'b110, 32'h104, 0, 32'h01234567, 0, 1, 32'h104, 4'b0000, 0,
          32'h01234567, 0, 0, 2, 0);
  endtask

  task automatic test_stores();
    do_op("sb", 0, 1, 3'b000, 32'h201, 32'h000000A5, 32'hFFFFFFFF, 3, 1, 32'h200, 4'b0010,
          32'hA5A5A5A5, 32'h0, 0, 0, 5, 0);
    do_op("sh", 0, 1, 3'b001, 32'h202, 32'h1234BEEF, 0, 0, 1, 32'h200, 4'b1100,
          32'hBEEFBEEF, 32'h0, 0, 0, 2, 0);
    do_op("sw", 0, 1, 3'b010, 32'h300, 32'hCAFEF00D, 0, 2, 1, 32'h300, 4'b1111,
          32'hCAFEF00D, 32'h0, 0, 0, 4, 0);
  endtask

  task automatic test_misalign();
    do_op("lh_mis", 1, 0, 3'b001, 32'h101, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 32'h0, 1, 0, 1, 0);
    do_op("sw_mis", 0, 1, 3'b010, 32'h102, 32'h5, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 1, 0);
    do_op("ld011", 1, 0, 3'b011, 32'h100, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 32'h0, 1, 0, 1, 0);
    do_op("st100", 0, 1, 3'b100, 32'h100, 32'h7, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 1, 0);
    do_op("both", 1, 1, 3'b010, 32'h100, 32'h7, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 1, 0);
  endtask

  task automatic test_ignore();
    start = 1; load = 0; store = 0; fun3 = 3'b010; addr = 32'h100;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || dmem_req !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL no_strobe: got busy=%b req=%b done=%b want 0 0 0", busy, dmem_req, done);
      end
    end
    @(posedge clk); #1;
    drive_idle();
  endtask

  task automatic test_back_to_back();
    // Start held high with a store while busy must not start a second access.
    do_op("busy_hold", 1, 0, 3'b000, 32'h402, 0, 32'h00C30000, 2, 1, 32'h400, 4'b0000, 0,
          32'hFFFFFFC3, 0, 0, 4, 1);
    do_op("b2b_lhu", 1, 0, 3'b101, 32'h400, 0, 32'h0000F00F, 0, 1, 32'h400, 4'b0000, 0,
          32'h0000F00F, 0, 0, 2, 0);
    do_op("b2b_sb3", 0, 1, 3'b000, 32'h403, 32'h3C, 0, 0, 1, 32'h400, 4'b1000, 32'h3C3C3C3C,
          32'h0, 0, 0, 2, 0);
  endtask

  task automatic test_reset_mid();
    start = 1; load = 1; store = 0; fun3 = 3'b010; addr = 32'h500; dmem_rdata = 32'h0;
    @(posedge clk); #1;
    start = 0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (dmem_req !== 1'b1) begin
        errors++;
        $display("FAIL rst_mid_req: got %b want 1", dmem_req);
      end
    end
    rst = 1;
    @(posedge clk); #1;
    checks++;
    if (dmem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_drop: got req=%b busy=%b done=%b want 0 0 0", dmem_req, busy, done);
    end
    rst = 0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_quiet: got done=%b busy=%b want 0 0", done, busy);
      end
    end
    @(posedge clk); #1;
    drive_idle();
    do_op("lw_after_rst", 1, 0, 3'b010, 32'h504, 0, 32'h13579BDF, 0, 1, 32'h504, 4'b0000, 0,
          32'h13579BDF, 0, 0, 2, 0);
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    do_op("timeout", 1, 0, 3'b010, 32'h600, 0, 32'hFFFFFFFF, 1000, 1, 32'h600, 4'b0000, 0,
          32'h0, 0, 1, TbTimeout + 2, 0);
    do_op("ack_at_limit", 1, 0, 3'b010, 32'h600, 0, 32'h24682468, TbTimeout, 1, 32'h600,
          4'b0000, 0, 32'h24682468, 0, 0, TbTimeout + 2, 0);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_misalign();
    test_ignore();
    test_back_to_back();
    test_reset_mid();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Memory-access stage directly downstream of the control decoder. It consumes the decoded Load/Store strobes and fun3, the ALU-computed address and the rs2 store data.
- Performs one byte/half/word access per request over a req/ack data-memory handshake, using byte-lane steering and load sign/zero extension.
- Asserts busy to stall the pipeline while an access is in flight, and returns write-back data to the mem_to_reg mux.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.
- TIMEOUT_CYCLES, 255, maximum wait for dmem_ack in REQ state; used only when LSU_TIMEOUT_EN is defined.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  execute stage presents a valid memory op this cycle
- load  in  1  decoded Load strobe
- store  in  1  decoded Store strobe
- fun3  in  3  access size/sign code
- addr  in  XLEN  byte address (ALU result)
- store_data  in  XLEN  rs2 value
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle completion pulse
- load_data  out  XLEN  extended load result; valid while done is high
- misalign_err  out  1  one-cycle pulse with done: misaligned or illegal op
- bus_err  out  1  one-cycle pulse with done: access timed out (LSU_TIMEOUT_EN only; otherwise tied 0)
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  XLEN  word-aligned address {addr[31:2],2'b00}
- dmem_wdata  out  XLEN  lane-replicated store data
- dmem_wstrb  out  4  byte enables (0000 for reads)
- dmem_ack  in  1  memory completes the access this cycle
- dmem_rdata  in  XLEN  read word, valid with dmem_ack

Behaviour:
- Reset: all outputs 0 and state IDLE. A reset applied mid-access drops dmem_req at that edge and does not generate done.
- States: IDLE, REQ, RESP.
- IDLE:
  - start & (load XOR store): register op, fun3, addr and store_data.
  - If the op is legal and aligned, go to REQ; otherwise go to RESP with err set.
  - start with neither strobe: ignored.
  - start with both strobes: illegal, go to RESP with misalign_err.
- Legal fun3:
  - Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu, 110 treated as lw (RV32).
  - Stores: 000 sb, 001 sh, 010 sw.
  - Any other fun3 is illegal (misalign_err).
- Alignment: half requires addr[0]=0; word requires addr[1:0]=00.
- REQ:
  - dmem_req=1, with dmem_addr/we/wdata/wstrb held stable until dmem_ack.
  - On dmem_ack, capture dmem_rdata and go to RESP. A combinational ack in the first REQ cycle is legal.
- RESP: done=1 for exactly one cycle with load_data and error flags valid, then go to IDLE.
  - Store: load_data=0.
  - Error: load_data=0 and no memory request was issued.
- Latency: with ack in the first REQ cycle, done occurs 2 cycles after the start cycle. Each wait cycle adds 1.
- start while busy is ignored; upstream must hold the instruction using busy.
- Store lanes, with o=addr[1:0]:
  - sb: wstrb=0001<<o, wdata={4{sd[7:0]}}.
  - sh: wstrb=0011 (o=00) or 1100 (o=10), wdata={2{sd[15:0]}}.
  - sw: wstrb=1111, wdata=sd.
- Load extract: select byte rdata[8*o+:8] or half rdata[16*o[1]+:16].
  - lb/lh sign-extend.
  - lbu/lhu zero-extend.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to REQ and increments each REQ cycle without ack.
  - When the count reaches TIMEOUT_CYCLES with no ack, dmem_req is dropped and the block goes to RESP with bus_err=1 and load_data=0.
  - An ack arriving on the same cycle the count reaches TIMEOUT_CYCLES wins (normal completion).
- Undefined: no counter; REQ waits indefinitely and bus_err is constant 0.

Test Plan:
- lw at 0x100, rdata=0xDEADBEEF, ack on the first REQ cycle -> dmem_addr=0x100, wstrb=0000, done 2 cycles after start, load_data=0xDEADBEEF.
- lb at 0x103, rdata=0x80123456 -> load_data=0xFFFFFF80; lbu at the same address -> 0x00000080; lhu at 0x102 -> 0x00008012.
- sb at 0x201, store_data=0x000000A5, ack after 3 wait cycles -> wstrb=0010, wdata=0xA5A5A5A5, dmem_we=1, busy high for 5 cycles, done once.
- lh at 0x101 and sw at 0x102 -> no dmem_req, done+misalign_err 1 cycle after start; fun3=011 load -> misalign_err.
- rst asserted during REQ wait -> dmem_req=0 and busy=0 after that edge, no done; a new lw then completes normally.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, ack never arrives -> dmem_req is dropped and done+bus_err is pulsed.
